// File: rtl/segasys1_chrom_arb.sv
// rtl/segasys1_chrom_arb.sv - two-requester chip-ROM arbiter (sprite/background), IDLE/ISSUE/WAIT/DONE
// Optional per-requester one-entry read cache: define CHROM_ARB_CACHE_EN.
module segasys1_chrom_arb (
    input  logic        VCLKx4,
    input  logic        RESET,
    input  logic        SP_REQ,
    input  logic [17:0] SP_AD,
    output logic        SP_ACK,
    output logic [7:0]  SP_DT,
    input  logic        BG_REQ,
    input  logic [17:0] BG_AD,
    output logic        BG_ACK,
    output logic [7:0]  BG_DT,
    output logic        ROM_RD,
    output logic [17:0] ROM_AD,
    input  logic [7:0]  ROM_DT,
    input  logic        ROM_VLD,
    input  logic        PRIO,
    output logic        BUSY,
    output logic        GRANT,
    output logic        ERR
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Last WAIT count before the timeout fires; the counter then reads 255.
    localparam logic [7:0] CNT_LAST = 8'd254;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic [17:0] rom_ad_q, rom_ad_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  sp_dt_q, sp_dt_d;
    logic [7:0]  bg_dt_q, bg_dt_d;
    logic        err_q, err_d;
    logic        win_bg;

    // Tie under round-robin goes to whichever side did not own the last grant.
    assign win_bg = (SP_REQ && BG_REQ) ? (!PRIO && !grant_q) : BG_REQ;

`ifdef CHROM_ARB_CACHE_EN
    logic [17:0] sp_c_ad_q, sp_c_ad_d, bg_c_ad_q, bg_c_ad_d;
    logic [7:0]  sp_c_dt_q, sp_c_dt_d, bg_c_dt_q, bg_c_dt_d;
    logic        sp_c_vld_q, sp_c_vld_d, bg_c_vld_q, bg_c_vld_d;
    logic        hit;

    assign hit = win_bg ? (bg_c_vld_q && (bg_c_ad_q == BG_AD))
                        : (sp_c_vld_q && (sp_c_ad_q == SP_AD));
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rom_ad_d = rom_ad_q;
        cnt_d    = cnt_q;
        sp_dt_d  = sp_dt_q;
        bg_dt_d  = bg_dt_q;
        err_d    = err_q;
`ifdef CHROM_ARB_CACHE_EN
        sp_c_ad_d  = sp_c_ad_q;
        sp_c_dt_d  = sp_c_dt_q;
        sp_c_vld_d = sp_c_vld_q;
        bg_c_ad_d  = bg_c_ad_q;
        bg_c_dt_d  = bg_c_dt_q;
        bg_c_vld_d = bg_c_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (SP_REQ || BG_REQ) begin
                    grant_d  = win_bg;
                    rom_ad_d = win_bg ? BG_AD : SP_AD;
                    state_d  = S_ISSUE;
`ifdef CHROM_ARB_CACHE_EN
                    if (hit) begin
                        state_d = S_DONE;
                        if (win_bg) bg_dt_d = bg_c_dt_q;
                        else        sp_dt_d = sp_c_dt_q;
                    end
`endif
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ROM_VLD) begin
                    if (grant_q) bg_dt_d = ROM_DT;
                    else         sp_dt_d = ROM_DT;
`ifdef CHROM_ARB_CACHE_EN
                    if (grant_q) begin
                        bg_c_ad_d  = rom_ad_q;
                        bg_c_dt_d  = ROM_DT;
                        bg_c_vld_d = 1'b1;
                    end else begin
                        sp_c_ad_d  = rom_ad_q;
                        sp_c_dt_d  = ROM_DT;
                        sp_c_vld_d = 1'b1;
                    end
`endif
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = 8'hFF;
                    if (grant_q) bg_dt_d = 8'hFF;
                    else         sp_dt_d = 8'hFF;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            grant_q  <= 1'b1;
            rom_ad_q <= 18'd0;
            cnt_q    <= 8'd0;
            sp_dt_q  <= 8'd0;
            bg_dt_q  <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rom_ad_q <= rom_ad_d;
            cnt_q    <= cnt_d;
            sp_dt_q  <= sp_dt_d;
            bg_dt_q  <= bg_dt_d;
            err_q    <= err_d;
        end
    end

`ifdef CHROM_ARB_CACHE_EN
    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            sp_c_ad_q  <= 18'd0;
            sp_c_dt_q  <= 8'd0;
            sp_c_vld_q <= 1'b0;
            bg_c_ad_q  <= 18'd0;
            bg_c_dt_q  <= 8'd0;
            bg_c_vld_q <= 1'b0;
        end else begin
            sp_c_ad_q  <= sp_c_ad_d;
            sp_c_dt_q  <= sp_c_dt_d;
            sp_c_vld_q <= sp_c_vld_d;
            bg_c_ad_q  <= bg_c_ad_d;
            bg_c_dt_q  <= bg_c_dt_d;
            bg_c_vld_q <= bg_c_vld_d;
        end
    end
`endif

    assign ROM_RD = (state_q == S_ISSUE);
    assign ROM_AD = rom_ad_q;
    assign SP_ACK = (state_q == S_DONE) && !grant_q;
    assign BG_ACK = (state_q == S_DONE) && grant_q;
    assign SP_DT  = sp_dt_q;
    assign BG_DT  = bg_dt_q;
    assign BUSY   = (state_q != S_IDLE);
    assign GRANT  = grant_q;
    assign ERR    = err_q;

endmodule

// File: doc/segasys1_chrom_arb.md
SEGASYS1_CHROM_ARB -- requirements
Module: segasys1_chrom_arb

Interface
REQ-001 SHALL have port VCLKx4  in  1  sole clock; all logic on its rising edge.
REQ-002 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports SP_REQ in 1, SP_AD in 18, SP_ACK out 1, SP_DT out 8: sprite-engine chip-ROM requester.
REQ-004 SHALL have ports BG_REQ in 1, BG_AD in 18, BG_ACK out 1, BG_DT out 8: background-tile requester.
REQ-005 SHALL have ports ROM_RD out 1, ROM_AD out 18, ROM_DT in 8, ROM_VLD in 1: shared chip-ROM port.
REQ-006 SHALL have port PRIO  in  1  0 = round-robin, 1 = sprite fixed priority.
REQ-007 SHALL have ports BUSY out 1 (state != IDLE), GRANT out 1 (0 = sprite, 1 = bg, current/last owner), ERR out 1 (sticky timeout flag).

Function
REQ-008 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-009 IDLE: if any REQ high, SHALL select winner, latch its AD into ROM_AD, set GRANT, go to ISSUE; else stay.
REQ-010 Arbitration: single request wins; both high with PRIO=1 -> sprite; both with PRIO=0 -> requester not granted last.
REQ-011 ISSUE: ROM_RD SHALL be high for exactly this one cycle; WAIT-counter cleared; next WAIT.
REQ-012 WAIT: on ROM_VLD SHALL capture ROM_DT into winner's DT register and go to DONE.
REQ-013 WAIT: 8-bit counter increments each cycle without ROM_VLD; on reaching 255 SHALL load 0xFF into winner's DT, set ERR, go to DONE.
REQ-014 DONE: winner's ACK SHALL be high for exactly one cycle, DT valid from this cycle until that requester's next ACK; next IDLE.
REQ-015 Minimum latency: REQ sampled at edge N -> ROM_RD high cycle N+1 -> ROM_VLD earliest N+2 -> ACK high cycle N+3.
REQ-016 Requester SHALL hold REQ and AD stable until ACK; REQ still high in IDLE after ACK is a new request with current AD.
REQ-017 ROM_VLD outside WAIT SHALL be ignored (no DT change, no ACK).
REQ-018 Non-winning requester's DT and ACK SHALL be unaffected by the other's transaction.
REQ-019 PRIO SHALL be sampled only in IDLE at arbitration; changes mid-transaction have no effect on it.
REQ-020 ROM_AD SHALL stay stable from ISSUE through DONE.

Reset
REQ-021 RESET SHALL force IDLE, ROM_RD=0, SP_ACK=0, BG_ACK=0, BUSY=0, ERR=0, GRANT=1 (so sprite wins first round-robin tie), ROM_AD=0, SP_DT=0, BG_DT=0, WAIT-counter=0.
REQ-022 RESET mid-transaction SHALL abandon it with no ACK; a late ROM_VLD SHALL be ignored.

Configuration
REQ-023 Macro CHROM_ARB_CACHE_EN defined: per-requester one-entry cache (address 18b, data 8b, valid), valid cleared by RESET, updated on every ROM-sourced DONE (not timeout).
REQ-024 With cache: in IDLE, if winner's AD equals its valid cached address, SHALL skip ISSUE/WAIT, go directly to DONE with cached data; no ROM_RD; ACK next cycle after REQ sampled.
REQ-025 Without CHROM_ARB_CACHE_EN: no cache logic; every request performs a ROM access per REQ-009..014.

Verification
REQ-026 SP_REQ=1, SP_AD=0x12345, ROM_VLD one cycle after ROM_RD with ROM_DT=0xA5 -> ROM_AD=0x12345, SP_ACK at cycle N+3, SP_DT=0xA5, BG_ACK never high.
REQ-027 Both REQ high from reset, PRIO=0, repeated 4 times -> grants S,B,S,B; PRIO=1 same stimulus -> S,S,S,S while SP_REQ held.
REQ-028 SP_REQ=1, ROM_VLD never asserted -> SP_ACK 257 cycles after ISSUE region start (ISSUE+255 WAIT+DONE), SP_DT=0xFF, ERR=1 until RESET.
REQ-029 RESET asserted during WAIT, ROM_VLD pulsed 2 cycles later -> no ACK, BUSY=0, DT registers 0.
REQ-030 CACHE_EN: two BG requests to 0x00100 (ROM_DT=0x3C) -> one ROM_RD total, second BG_ACK one cycle after sampling, BG_DT=0x3C; without macro -> two ROM_RD.
